// File: rtl/bus_mem_pkg.sv
// Shared constants and state type for the CPU-side memory responder.
package bus_mem_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;

   localparam logic [7:0] DEF_IO_IN_ADDR  = 8'hFE;
   localparam logic [7:0] DEF_IO_OUT_ADDR = 8'hFF;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/bus_ram.sv
// Single-port synchronous-read RAM; a same-address write returns the old byte.
module bus_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              re,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   // Array is deliberately not reset so a reload can keep earlier contents.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/bus_memory_responder.sv
// Memory responder for the 8-bit CPU: program loader, 256-byte RAM and two I/O bytes.
//
//   state | meaning
//   LOAD  | CPU held; loader bytes written to RAM from load_ptr upward
//   RUN   | CPU runs; reads/writes served from RAM or the I/O bytes
module bus_memory_responder
   import bus_mem_pkg::*;
#(
   parameter int                ADDR_W      = DEF_ADDR_W,
   parameter int                DATA_W      = DEF_DATA_W,
   parameter logic [ADDR_W-1:0] IO_IN_ADDR  = DEF_IO_IN_ADDR,
   parameter logic [ADDR_W-1:0] IO_OUT_ADDR = DEF_IO_OUT_ADDR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              we,
   output logic [DATA_W-1:0] rdata,
   output logic              cpu_run,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_valid,
   input  logic              load_last,
   output logic              load_ready,
   input  logic              load_start,
   input  logic [DATA_W-1:0] io_in,
   output logic [DATA_W-1:0] io_out,
   output logic              io_strobe
);

   state_t            state;
   logic [ADDR_W-1:0] load_ptr;
   logic              io_sel;
   logic [DATA_W-1:0] io_q;

   logic              ram_re;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   // The loader owns the RAM port in LOAD, the CPU owns it in RUN.
   always_comb begin
      ram_re    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = addr;
      ram_wdata = wdata;
      if (state == LOAD) begin
         ram_we    = load_valid;
         ram_addr  = load_ptr;
         ram_wdata = load_data;
      end else begin
         ram_re = 1'b1;
         ram_we = we && (addr != IO_OUT_ADDR);
      end
   end

   bus_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .re    (ram_re),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= LOAD;
         load_ptr   <= '0;
         cpu_run    <= 1'b0;
         load_ready <= 1'b1;
         io_out     <= '0;
         io_strobe  <= 1'b0;
      end else begin
         io_strobe <= 1'b0;
         case (state)
            LOAD: begin
               if (load_valid) begin
                  load_ptr <= load_ptr + ADDR_W'(1);
                  // Last byte, or the pointer is about to wrap on a full image.
                  if (load_last || (load_ptr == '1)) begin
                     state      <= RUN;
                     cpu_run    <= 1'b1;
                     load_ready <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (we && (addr == IO_OUT_ADDR)) begin
                  io_out    <= wdata;
                  io_strobe <= 1'b1;
               end
               if (load_start) begin
                  state      <= LOAD;
                  load_ptr   <= '0;
                  cpu_run    <= 1'b0;
                  load_ready <= 1'b1;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   // io_in is captured alongside the RAM read so both paths share one cycle of latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         io_sel <= 1'b0;
         io_q   <= '0;
      end else if (state == RUN) begin
         io_sel <= (addr == IO_IN_ADDR);
         io_q   <= io_in;
      end
   end

   assign rdata = io_sel ? io_q : ram_rdata;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench for bus_memory_responder: loader, RUN reads/writes, I/O bytes, resets.
module tb_bus_memory_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] addr = '0;
   logic [7:0] wdata = '0;
   logic       we = 1'b0;
   logic [7:0] rdata;
   logic       cpu_run;
   logic [7:0] load_data = '0;
   logic       load_valid = 1'b0;
   logic       load_last = 1'b0;
   logic       load_ready;
   logic       load_start = 1'b0;
   logic [7:0] io_in = '0;
   logic [7:0] io_out;
   logic       io_strobe;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   bus_memory_responder dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .wdata      (wdata),
      .we         (we),
      .rdata      (rdata),
      .cpu_run    (cpu_run),
      .load_data  (load_data),
      .load_valid (load_valid),
      .load_last  (load_last),
      .load_ready (load_ready),
      .load_start (load_start),
      .io_in      (io_in),
      .io_out     (io_out),
      .io_strobe  (io_strobe)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      tick();
      rst = 1'b0;
      tick();
      total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h want=00", rdata); end
      total++; if (cpu_run !== 1'b0) begin bad++; $display("FAIL reset_cpu_run got=%b want=0", cpu_run); end
      total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_load_ready got=%b want=1", load_ready); end
      total++; if (io_out !== 8'h00) begin bad++; $display("FAIL reset_io_out got=%h want=00", io_out); end
      total++; if (io_strobe !== 1'b0) begin bad++; $display("FAIL reset_io_strobe got=%b want=0", io_strobe); end
   endtask

   task automatic test_load_three();
      logic [7:0] bytes [3] = '{8'h01, 8'h10, 8'h2A};
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_data  = bytes[i];
         load_last  = (i == 2);
         tick();
         if (i < 2) begin
            total++; if (cpu_run !== 1'b0) begin bad++; $display("FAIL load3_run_early i=%0d got=%b want=0", i, cpu_run); end
         end
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      total++; if (cpu_run !== 1'b1) begin bad++; $display("FAIL load3_cpu_run got=%b want=1", cpu_run); end
      total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL load3_load_ready got=%b want=0", load_ready); end
   endtask

   task automatic test_read();
      logic [7:0] exp [3] = '{8'h01, 8'h10, 8'h2A};
      for (int i = 2; i >= 0; i--) begin
         addr = 8'(i);
         tick();
         total++; if (rdata !== exp[i]) begin bad++; $display("FAIL read_ram a=%0d got=%h want=%h", i, rdata, exp[i]); end
      end
      io_in = 8'h5C;
      addr  = 8'hFE;
      tick();
      total++; if (rdata !== 8'h5C) begin bad++; $display("FAIL read_io_in got=%h want=5C", rdata); end
   endtask

   task automatic test_read_before_write();
      we = 1'b1; addr = 8'h10; wdata = 8'h00;
      tick();
      wdata = 8'hAB;
      tick();
      total++; if (rdata !== 8'h00) begin bad++; $display("FAIL rbw_old got=%h want=00", rdata); end
      we = 1'b0;
      tick();
      total++; if (rdata !== 8'hAB) begin bad++; $display("FAIL rbw_new got=%h want=AB", rdata); end
   endtask

   task automatic test_load_start();
      load_start = 1'b1; we = 1'b1; addr = 8'hFF; wdata = 8'h33;
      tick();
      load_start = 1'b0; we = 1'b0;
      total++; if (cpu_run !== 1'b0) begin bad++; $display("FAIL ls_cpu_run got=%b want=0", cpu_run); end
      total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL ls_load_ready got=%b want=1", load_ready); end
      total++; if (io_out !== 8'h33) begin bad++; $display("FAIL ls_io_out got=%h want=33", io_out); end
      total++; if (io_strobe !== 1'b1) begin bad++; $display("FAIL ls_io_strobe got=%b want=1", io_strobe); end
      tick();
      total++; if (io_strobe !== 1'b0) begin bad++; $display("FAIL ls_strobe_clear got=%b want=0", io_strobe); end
   endtask

   task automatic test_full_load();
      for (int i = 0; i < 256; i++) begin
         load_valid = 1'b1;
         load_data  = 8'(i) ^ 8'hA5;
         tick();
         if (i == 254) begin
            total++; if (cpu_run !== 1'b0) begin bad++; $display("FAIL full_run_early got=%b want=0", cpu_run); end
         end
      end
      total++; if (cpu_run !== 1'b1) begin bad++; $display("FAIL full_cpu_run got=%b want=1", cpu_run); end
      load_data = 8'hEE;
      tick();
      tick();
      load_valid = 1'b0;
      total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL full_load_ready got=%b want=0", load_ready); end
      io_in = 8'h3C;
      for (int i = 0; i < 256; i++) begin
         logic [7:0] exp;
         addr = 8'(i);
         exp  = (i == 254) ? 8'h3C : (8'(i) ^ 8'hA5);
         tick();
         total++; if (rdata !== exp) begin bad++; $display("FAIL full_read a=%0d got=%h want=%h", i, rdata, exp); end
      end
   endtask

   task automatic test_io_write();
      we = 1'b1; addr = 8'hFF; wdata = 8'h77;
      tick();
      we = 1'b0;
      total++; if (io_out !== 8'h77) begin bad++; $display("FAIL io_out got=%h want=77", io_out); end
      total++; if (io_strobe !== 1'b1) begin bad++; $display("FAIL io_strobe got=%b want=1", io_strobe); end
      tick();
      total++; if (io_strobe !== 1'b0) begin bad++; $display("FAIL io_strobe_single got=%b want=0", io_strobe); end
      total++; if (rdata !== 8'h5A) begin bad++; $display("FAIL io_read_ff got=%h want=5A", rdata); end
      we = 1'b1; wdata = 8'h41;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (io_strobe !== 1'b1) begin bad++; $display("FAIL io_held_strobe i=%0d got=%b want=1", i, io_strobe); end
      end
      we = 1'b0;
      tick();
      total++; if (io_strobe !== 1'b0) begin bad++; $display("FAIL io_held_end got=%b want=0", io_strobe); end
   endtask

   task automatic test_reset_mid_load();
      addr = 8'h00;
      tick();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         load_valid = 1'b1;
         load_data  = 8'h11 + 8'(i);
         tick();
      end
      load_valid = 1'b0;
      total++; if (rdata !== 8'hA5) begin bad++; $display("FAIL mid_rdata_held got=%h want=A5", rdata); end
      #2 rst = 1'b1;
      #1;
      total++; if (rdata !== 8'h00) begin bad++; $display("FAIL mid_rst_rdata got=%h want=00", rdata); end
      total++; if (io_out !== 8'h00) begin bad++; $display("FAIL mid_rst_io_out got=%h want=00", io_out); end
      total++; if (cpu_run !== 1'b0) begin bad++; $display("FAIL mid_rst_cpu_run got=%b want=0", cpu_run); end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_data  = 8'h21 + 8'(i);
         load_last  = (i == 2);
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      begin
         logic [7:0] exp [7] = '{8'h21, 8'h22, 8'h23, 8'h14, 8'h15, 8'hA0, 8'hA3};
         for (int i = 0; i < 7; i++) begin
            addr = 8'(i);
            tick();
            total++; if (rdata !== exp[i]) begin bad++; $display("FAIL reload_read a=%0d got=%h want=%h", i, rdata, exp[i]); end
         end
      end
      #2 rst = 1'b1;
      #1;
      total++; if (cpu_run !== 1'b0) begin bad++; $display("FAIL run_rst_cpu_run got=%b want=0", cpu_run); end
      total++; if (rdata !== 8'h00) begin bad++; $display("FAIL run_rst_rdata got=%h want=00", rdata); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_load_three();
      test_read();
      test_read_before_write();
      test_load_start();
      test_full_load();
      test_io_write();
      test_reset_mid_load();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_memory_responder.md
Name: bus_memory_responder

Overview:
- Memory-side responder for the 8-bit CPU bus: it answers the CPU's addr/data_out/we requests and drives the CPU's data_in.
- Contains a 256x8 synchronous RAM, a byte-stream program loader that holds the CPU out of run until the image is written, and two memory-mapped I/O bytes (input port, output port).
- Sits between the CPU core and the top level; the CPU's clock-enable/run is gated by cpu_run.

Parameters:
- ADDR_W, 8, address width; RAM depth = 2**ADDR_W.
- DATA_W, 8, data width.
- IO_IN_ADDR, 8'hFE, read address that returns io_in instead of RAM.
- IO_OUT_ADDR, 8'hFF, write address that updates io_out instead of RAM.

Ports:
- clk  in  1  sole clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- addr  in  ADDR_W  CPU address.
- wdata  in  DATA_W  CPU write data (CPU data_out).
- we  in  1  CPU write enable.
- rdata  out  DATA_W  read data to the CPU (CPU data_in).
- cpu_run  out  1  high only in RUN; CPU advances only while high.
- load_data  in  DATA_W  loader byte.
- load_valid  in  1  loader byte valid.
- load_last  in  1  marks the final loader byte.
- load_ready  out  1  loader may transfer this cycle.
- load_start  in  1  one-cycle pulse requesting a reload from RUN.
- io_in  in  DATA_W  external input byte.
- io_out  out  DATA_W  external output byte register.
- io_strobe  out  1  one-cycle pulse when io_out is written.

Behaviour:
- Reset (async assert): state=LOAD, load_ptr=0, rdata=0, io_out=0, io_strobe=0, cpu_run=0, load_ready=1 on the first cycle after release. RAM contents are not cleared.
- States: LOAD, RUN. Register cpu_run and load_ready from state: cpu_run = (state==RUN); load_ready = (state==LOAD).
- LOAD:
  - Transfer occurs on load_valid & load_ready. On a transfer, write mem[load_ptr] <= load_data and increment load_ptr (mod 256).
  - Transfer with load_last=1 -> RUN next cycle.
  - Transfer at load_ptr==8'hFF without load_last -> ptr wraps to 0 and the block moves to RUN (full 256-byte image).
  - Loader bytes at 8'hFE/8'hFF go to RAM; the I/O mapping applies to CPU accesses only.
  - CPU we is ignored. rdata holds its value. load_start is ignored.
  - No transfer without load_valid; load_last without load_valid has no effect.
- RUN, read path:
  - rdata <= (addr==IO_IN_ADDR) ? io_in : mem[addr]. Registered, so latency is 1 cycle and data is valid on the edge after addr is presented.
  - Every cycle is a read; there is no read strobe.
- RUN, write path (when we=1):
  - addr==IO_OUT_ADDR: io_out <= wdata and io_strobe=1 for exactly that following cycle; RAM is not written.
  - Otherwise: mem[addr] <= wdata.
  - we held for N cycles produces N strobes/writes.
- Read/write same cycle, same address: rdata returns the OLD RAM content (read-before-write).
- load_valid in RUN: ignored, load_ready=0.
- load_start in RUN: next state LOAD, load_ptr=0, cpu_run falls the next cycle. A CPU write in that same cycle still completes. load_start coincident with we to IO_OUT_ADDR: both take effect.
- io_strobe is 0 in LOAD.
- Reset mid-load or mid-run: the immediate async return to reset values above; partially loaded RAM keeps its data.

Decomposition:
- Shared package bus_mem_pkg:
  - state enum {LOAD, RUN}
  - IO_IN_ADDR / IO_OUT_ADDR defaults
  - the ADDR_W/DATA_W default constants shared with the CPU.
- One sub-module, bus_ram:
  - single-port, synchronous-read, read-before-write 2**ADDR_W x DATA_W array with one write port.
  - The responder muxes loader vs CPU onto it by state.

Test Plan:
- Reset, then stream 3 bytes 8'h01,8'h10,8'h2A with load_last on the third -> mem[0..2]=01,10,2A; cpu_run rises the cycle after the third transfer; load_ready falls at the same time.
- In RUN, addr=8'h02 -> rdata=8'h2A one cycle later. addr=8'hFE with io_in=8'h5C -> rdata=8'h5C.
- In RUN, we=1, addr=8'hFF, wdata=8'h77 for one cycle -> io_out=8'h77 and a single-cycle io_strobe; a later read of 8'hFF returns the RAM byte, not 8'h77.
- we=1, addr=8'h10, wdata=8'hAB while mem[10]=8'h00 -> rdata=8'h00 that cycle; reading 8'h10 on the next cycle -> 8'hAB.
- Stream 256 bytes with no load_last -> entry to RUN after byte 256, load_ptr=0, all locations hold the streamed values; load_valid afterwards has no effect.
- Assert rst asynchronously mid-load after 5 bytes -> cpu_run=0, rdata=0, io_out=0 immediately. Reload from ptr 0 works, and bytes 5.. keep their old values until overwritten. Pulse load_start in RUN -> LOAD, cpu_run=0 on the next cycle.
